// File: rtl/soc_led_dimmer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : soc_led_dimmer_if
// Brief    : Avalon-MM register slave bundle for the LED dimmer.
// Revision : 1.0 - initial release
// ============================================================================
interface soc_led_dimmer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/soc_led_dimmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : soc_led_dimmer
// Brief    : PWM dimmer/blinker between the LED PIO and the board LED pins.
//            Define SOC_LED_DIMMER_GAMMA_EN for a squared (gamma) duty curve.
// Revision : 1.0 - initial release
// ============================================================================
module soc_led_dimmer (
  input  logic                    clk,
  input  logic                    reset_n,
  soc_led_dimmer_if.slave         bus,
  input  logic [13:0]             led_in,
  output logic [13:0]             led_out
);

  logic [7:0]  duty_q, duty_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] blink_q, blink_d;
  logic        en_q, en_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  act_duty_q, act_duty_d;
  logic [13:0] shadow_q, shadow_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [13:0] led_out_q, led_out_d;

  logic        wr_en;
  logic        tick;
  logic        pb;
  logic        pwm_on;
  logic [7:0]  duty_curve;
  logic [31:0] rdata;

  assign wr_en  = bus.chipselect & ~bus.write_n;
  assign tick   = (presc_cnt_q == prescale_q);
  assign pb     = tick & (pwm_cnt_q == 8'hFF);
  assign pwm_on = (act_duty_q == 8'hFF) | (pwm_cnt_q < act_duty_q);

`ifdef SOC_LED_DIMMER_GAMMA_EN
  logic [15:0] duty_sq;
  assign duty_sq    = {8'd0, duty_q} * {8'd0, duty_q};
  assign duty_curve = (duty_q == 8'hFF) ? 8'hFF : 8'(duty_sq >> 8);
`else
  assign duty_curve = duty_q;
`endif

  always_comb begin
    duty_d      = duty_q;
    prescale_d  = prescale_q;
    blink_d     = blink_q;
    en_d        = en_q;
    presc_cnt_d = presc_cnt_q + 16'd1;
    pwm_cnt_d   = pwm_cnt_q;
    act_duty_d  = act_duty_q;
    shadow_d    = shadow_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (tick) begin
      presc_cnt_d = 16'd0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end

    // Pattern and duty only change on a period boundary to avoid mid-period glitches.
    if (pb) begin
      shadow_d   = led_in;
      act_duty_d = duty_curve;
    end

    if (blink_q == 16'd0) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b0;
    end else if (pb) begin
      if (blink_cnt_q == blink_q - 16'd1) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    if (wr_en) begin
      unique case (bus.address)
        2'd0: duty_d = bus.writedata[7:0];
        2'd1: begin
          prescale_d  = bus.writedata[15:0];
          presc_cnt_d = 16'd0;
        end
        2'd2: begin
          blink_d     = bus.writedata[15:0];
          blink_cnt_d = 16'd0;
          phase_d     = 1'b0;
        end
        default: en_d = bus.writedata[0];
      endcase
    end

    led_out_d = (en_q & ~phase_q & pwm_on) ? shadow_q : 14'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q      <= 8'hFF;
      prescale_q  <= 16'd0;
      blink_q     <= 16'd0;
      en_q        <= 1'b1;
      presc_cnt_q <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      act_duty_q  <= 8'hFF;
      shadow_q    <= 14'd0;
      blink_cnt_q <= 16'd0;
      phase_q     <= 1'b0;
      led_out_q   <= 14'd0;
    end else begin
      duty_q      <= duty_d;
      prescale_q  <= prescale_d;
      blink_q     <= blink_d;
      en_q        <= en_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      act_duty_q  <= act_duty_d;
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
    end
  end

  // Readback returns the programmed DUTY, not the active (possibly gamma-mapped) value.
  always_comb begin
    rdata = 32'd0;
    unique case (bus.address)
      2'd0:    rdata = {24'd0, duty_q};
      2'd1:    rdata = {16'd0, prescale_q};
      2'd2:    rdata = {16'd0, blink_q};
      default: rdata = {30'd0, phase_q, en_q};
    endcase
  end

  assign bus.readdata = rdata;
  assign led_out      = led_out_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_led_dimmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_soc_led_dimmer
// Brief    : Self-checking bench for soc_led_dimmer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_led_dimmer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] led_in;
  logic [13:0] led_out;

  soc_led_dimmer_if bus ();

  soc_led_dimmer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: ticks counted since reset, PWM position = ticks mod 256,
  // PHASE = parity of (period boundaries since last BLINK write) / BLINK.
  int m_pdiv, m_ticks, m_pbs;
  int m_duty, m_presc, m_blink, m_en, m_act, m_shadow, m_led;

  function automatic int gamma(input int d);
`ifdef SOC_LED_DIMMER_GAMMA_EN
    return (d == 255) ? 255 : (d * d) / 256;
`else
    return d;
`endif
  endfunction

  function automatic int m_phase();
    return (m_blink == 0) ? 0 : ((m_pbs / m_blink) % 2);
  endfunction

  function automatic int exp_rd(input int a);
    case (a)
      0:       return m_duty;
      1:       return m_presc;
      2:       return m_blink;
      default: return (m_phase() << 1) | m_en;
    endcase
  endfunction

  task automatic model_reset();
    m_pdiv = 0; m_ticks = 0; m_pbs = 0;
    m_duty = 255; m_presc = 0; m_blink = 0; m_en = 1;
    m_act = 255; m_shadow = 0; m_led = 0;
  endtask

  task automatic model_edge();
    bit wr, tick, pb, on;
    int pwm, a;
    wr   = bus.chipselect && !bus.write_n;
    a    = int'(bus.address);
    tick = (m_pdiv == m_presc);
    pwm  = m_ticks % 256;
    pb   = tick && (pwm == 255);
    on   = (m_act == 255) || (pwm < m_act);
    m_led = (m_en == 1 && m_phase() == 0 && on) ? m_shadow : 0;
    if (tick) begin m_ticks++; m_pdiv = 0; end
    else m_pdiv++;
    if (pb) begin m_shadow = int'(led_in); m_act = gamma(m_duty); end
    if (wr && a == 2) m_pbs = 0;
    else if (pb) m_pbs++;
    if (wr) begin
      case (a)
        0: m_duty  = int'(bus.writedata & 32'hFF);
        1: begin m_presc = int'(bus.writedata & 32'hFFFF); m_pdiv = 0; end
        2: m_blink = int'(bus.writedata & 32'hFFFF);
        default: m_en = int'(bus.writedata & 32'h1);
      endcase
    end
  endtask

  // Inputs change on the falling edge; outputs are compared 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("led_out", {18'd0, led_out}, m_led);
    check_val("readdata", bus.readdata, exp_rd(int'(bus.address)));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    cycle();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic count_on(input logic [13:0] pat, output int cnt);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (led_out == pat) cnt++;
    end
  endtask

  int on_cnt;

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    led_in = 14'd0;
    model_reset();
    #2;
    check_val("rst_led_out", {18'd0, led_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      check_val("rst_reg", bus.readdata, exp_rd(a));
    end
    bus.address = 2'd0;

    // Full duty: pattern appears only after the first period boundary.
    led_in = 14'h2AAA;
    idle(300);
    check_val("full_duty_const", {18'd0, led_out}, 32'h2AAA);

    // Quarter duty.
    wr(2'd0, 32'h40);
    led_in = 14'h3FFF;
    idle(520);
    count_on(14'h3FFF, on_cnt);
    check_val("quarter_on_cnt", on_cnt, 64);
    check_val("duty_readback", bus.readdata, 32'h40);

    // Mid-period pattern change.
    wr(2'd0, 32'hFF);
    led_in = 14'h0001;
    idle(520);
    idle(100);
    led_in = 14'h0002;
    idle(400);

    // Blink with period of two PWM periods.
    bus.address = 2'd3;
    wr(2'd2, 32'd2);
    bus.address = 2'd3;
    idle(1100);
    wr(2'd2, 32'd0);

    // Enable off then back on.
    wr(2'd3, 32'd0);
    idle(10);
    wr(2'd3, 32'd1);
    idle(300);

    // Half duty: linear vs gamma curve.
    wr(2'd0, 32'h80);
    led_in = 14'h3FFF;
    idle(520);
    count_on(14'h3FFF, on_cnt);
`ifdef SOC_LED_DIMMER_GAMMA_EN
    check_val("half_on_cnt", on_cnt, 64);
`else
    check_val("half_on_cnt", on_cnt, 128);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) led_in = 14'($urandom);
      case ($urandom_range(0, 15))
        0: begin
          logic [1:0]  a;
          logic [31:0] d;
          a = 2'($urandom_range(0, 3));
          d = $urandom;
          if (a == 2'd1 || a == 2'd2) d = (d & 32'hFFFF_0000) | $urandom_range(0, 3);
          wr(a, d);
        end
        1: begin
          bus.address = 2'($urandom_range(0, 3)); bus.chipselect = 1'b1;
          bus.write_n = 1'b1; bus.writedata = $urandom;
          cycle();
          bus.chipselect = 1'b0;
        end
        2: begin
          bus.address = 2'($urandom_range(0, 3)); bus.chipselect = 1'b0;
          bus.write_n = 1'b0; bus.writedata = $urandom;
          cycle();
          bus.write_n = 1'b1;
        end
        default: begin
          bus.address = 2'($urandom_range(0, 3));
          cycle();
        end
      endcase
    end

    // Asynchronous reset mid-period.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd3, 32'd1);
    wr(2'd0, 32'hFF);
    led_in = 14'h1555;
    idle(600);
    check_val("pre_reset_led", {18'd0, led_out}, 32'h1555);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_reset_led", {18'd0, led_out}, 32'd0);
    model_reset();
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #0.5;
      check_val("async_reset_reg", bus.readdata, exp_rd(a));
    end
    bus.address = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(300);
    check_val("post_reset_led", {18'd0, led_out}, 32'h1555);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
